// File: rtl/y_unload_pkg.sv
// Shared constants and state encoding for the y snapshot unloader.
// The stream carries NUM_WORDS data beats followed by one checksum trailer beat.
package y_unload_pkg;

    localparam int Y_W       = 350;
    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 22;
    localparam int TRAIL_IDX = 22;
    localparam int IDX_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        TRAIL = 2'd2
    } state_t;

endpackage

// File: rtl/y_word_checksum.sv
// 16-bit add-accumulate (mod 2^16) with synchronous clear and enable.
// Clear has priority so a fresh snapshot always starts the sum from zero.
module y_word_checksum
    import y_unload_pkg::*;
(
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [WORD_W-1:0] i_data,
    output logic [WORD_W-1:0] o_acc
);

    logic [WORD_W-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + i_data;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/y_snapshot_unloader.sv
// Freezes the 350-bit y bus on snap and streams it LSB-first as 22 16-bit words
// plus a 16-bit checksum trailer over a valid/ready port.
module y_snapshot_unloader
    import y_unload_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [Y_W-1:0]    y,
    input  logic              snap,
    output logic              busy,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [IDX_W-1:0]  out_idx,
    output logic              overrun,
    output logic [1:0]        dbg_state
);

    // Handshake: a beat moves on a posedge with out_valid && out_ready; while
    // stalled, out_data/out_idx/out_last hold and out_valid stays high (rst aside).
    state_t                      r_state;
    logic [Y_W-1:0]              r_shadow;
    logic [IDX_W-1:0]            r_idx;
    logic                        r_valid;
    logic                        r_last;
    logic                        r_overrun;

    logic                        w_xfer;
    logic                        w_start;
    logic                        w_acc_clr;
    logic                        w_acc_en;
    logic [WORD_W-1:0]           w_acc;
    logic [WORD_W-1:0]           w_data;
    logic [8:0]                  w_bit_base;
    logic [NUM_WORDS*WORD_W-1:0] w_pad;

    assign w_xfer     = r_valid && out_ready;
    assign w_start    = (r_state == IDLE) && snap;
    assign w_acc_clr  = rst || w_start;
    assign w_acc_en   = (r_state == SEND) && w_xfer;
    assign w_pad      = {{(NUM_WORDS*WORD_W-Y_W){1'b0}}, r_shadow};
    assign w_bit_base = {r_idx, 4'b0000};

    // Data is a pure mux of held registers, so it is stable whenever idx/state are.
    always_comb begin
        w_data = '0;
        case (r_state)
            SEND:    w_data = w_pad[w_bit_base +: WORD_W];
            TRAIL:   w_data = w_acc;
            default: w_data = '0;
        endcase
    end

    y_word_checksum u_checksum (
        .clk    (clk),
        .i_clr  (w_acc_clr),
        .i_en   (w_acc_en),
        .i_data (w_data),
        .o_acc  (w_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shadow  <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (snap && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (snap) begin
                        r_shadow <= y;
                        r_idx    <= '0;
                        r_valid  <= 1'b1;
                        r_last   <= 1'b0;
                        r_state  <= SEND;
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        if (r_idx == IDX_W'(NUM_WORDS - 1)) begin
                            r_idx   <= IDX_W'(TRAIL_IDX);
                            r_last  <= 1'b1;
                            r_state <= TRAIL;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                TRAIL: begin
                    if (w_xfer) begin
                        r_idx   <= '0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign out_data  = w_data;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign out_idx   = r_idx;
    assign overrun   = r_overrun;
    assign dbg_state = r_state;

endmodule

// File: doc/y_snapshot_unloader.md
Name: y_snapshot_unloader

Overview:
Consumer for the 350-bit y observation bus produced by the fuzz designs under simulation-identity test. On a snap request it freezes y into a shadow register. It then streams the vector out LSB-first as 22 16-bit words over a valid/ready interface, followed by a 16-bit checksum trailer. This lets the comparison harness read and diff y across simulators through a narrow port.

Parameters:
Y_W, 350, width of observed y bus
WORD_W, 16, stream word width
NUM_WORDS, 22, ceil(Y_W/WORD_W); upper pad bits of the last word are zero

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  reset, synchronous, active-high
y  input  350  observed bus, bit 0 = LSB
snap  input  1  capture request
busy  output  1  high while not IDLE
out_data  output  16  stream word
out_valid  output  1  word valid
out_ready  input  1  downstream accept
out_last  output  1  marks the checksum trailer beat
out_idx  output  5  beat index: 0..21 data, 22 trailer
overrun  output  1  sticky flag: snap arrived while busy

Behaviour:
- Reset (sync, active-high): state=IDLE; out_valid=0, out_last=0, out_idx=0, out_data=0, busy=0, overrun=0, shadow=0, checksum accumulator=0. rst wins over every other input in the same cycle.
- Transfer: a beat transfers on a posedge where out_valid && out_ready.
- Valid/ready rule: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable. out_valid never drops before its beat transfers, except on rst.
- IDLE:
  - snap=1 -> shadow<=y, idx<=0, acc<=0, state<=SEND.
  - out_valid rises on the cycle after snap (1-cycle latency); word 0 is presented then.
- SEND:
  - out_data = shadow[idx*16 +: 16]. Word 21 = {2'b00, shadow[349:336]}.
  - On each transfer: acc <= acc + out_data (mod 2^16), idx++.
  - Transfer at idx=21 -> state<=TRAIL, idx<=22.
- TRAIL:
  - out_data = acc (sum of all 22 data words mod 2^16), out_last=1, out_valid=1.
  - Transfer -> state<=IDLE, out_valid<=0, out_last<=0, idx<=0.
  - A new snap may be accepted in the cycle after return to IDLE; snap in the same cycle as the trailer transfer counts as an overrun.
- Snap while busy (SEND/TRAIL): ignored. The shadow register is not modified and overrun<=1 (sticky until rst).
- y changing after capture has no effect on the stream in flight.
- rst mid-stream: abort. Next cycle is IDLE with out_valid=0 and acc cleared; no trailer is emitted.
- Minimum unload time with ready held high: 23 beats, i.e. snap to last-beat transfer = 24 cycles.

Decomposition:
- Package y_unload_pkg holds:
  - constants Y_W, WORD_W, NUM_WORDS, TRAIL_IDX=22;
  - enum state_t {IDLE, SEND, TRAIL}.
- One sub-module is natural: y_word_checksum. It is a 16-bit add-accumulate with clear and enable, instantiated once.
- Word selection is an indexed part-select of the shadow register; no separate module.

Test Plan:
- y all zeros, snap, ready=1 -> 22 beats of 0x0000 at idx 0..21, then trailer 0x0000 with out_last=1 at idx 22; busy drops the cycle after.
- y all ones, ready=1 -> words 0..20 = 0xFFFF, word 21 = 0x3FFF, trailer 0x3FEA.
- y = 1<<0 -> word0 = 0x0001, trailer 0x0001. Separately, y = 1<<349 -> word21 = 0x2000, trailer 0x2000.
- Backpressure: y = all ones, ready=0 for 3 cycles while idx=5 is presented -> out_data=0xFFFF and out_idx=5 held; stream resumes and the trailer is still 0x3FEA.
- Snap pulsed at idx 10 with a different y -> stream and trailer unchanged, overrun=1 and stays 1 through the next snap until rst.
- rst asserted at idx 7 -> next cycle out_valid=0, busy=0, idx=0, overrun=0. A following snap with y=1<<0 yields a clean stream with trailer 0x0001.
